// File: rtl/bcd_display_converter_pkg.sv
// rtl/bcd_display_converter_pkg.sv - shared types and constants for the BCD display converter
package bcd_display_converter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_S = 2'd1,
    CONV_T = 2'd2,
    DONE   = 2'd3
  } conv_state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int SCORE_DIGITS  = 4;
  localparam int TIME_DIGITS   = 2;
  localparam int SCORE_MAX_DEF = 9999;

endpackage

// File: rtl/bcd_shift_step.sv
// rtl/bcd_shift_step.sv - one double-dabble iteration: add 3 to nibbles >= 5, then shift left
module bcd_shift_step
  import bcd_display_converter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic [DIGITS*BCD_DIGIT_W+BIN_W-1:0] din,
  output logic [DIGITS*BCD_DIGIT_W+BIN_W-1:0] dout
);

  localparam int W = DIGITS*BCD_DIGIT_W + BIN_W;

  logic [W-1:0] adj;

  always_comb begin
    adj = din;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[BIN_W+i*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5)
        adj[BIN_W+i*BCD_DIGIT_W +: BCD_DIGIT_W] = adj[BIN_W+i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
    end
    // binary MSB moves into the BCD least-significant bit
    dout = {adj[W-2:0], 1'b0};
  end

endmodule

// File: rtl/bcd_display_converter.sv
// rtl/bcd_display_converter.sv - sequential score/timer binary-to-BCD converter for the 7-segment digits
module bcd_display_converter
  import bcd_display_converter_pkg::*;
#(
  parameter int SCORE_W   = 14,
  parameter int TIME_W    = 6,
  parameter int SCORE_MAX = SCORE_MAX_DEF,
  parameter bit AUTO      = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [SCORE_W-1:0]                  score,
  input  logic [TIME_W-1:0]                   timer,
  output logic [SCORE_DIGITS*BCD_DIGIT_W-1:0] score_bcd,
  output logic [TIME_DIGITS*BCD_DIGIT_W-1:0]  timer_bcd,
  output logic                                busy,
  output logic                                done
);

  localparam int SB_W  = SCORE_DIGITS*BCD_DIGIT_W;
  localparam int TB_W  = TIME_DIGITS*BCD_DIGIT_W;
  localparam int SS_W  = SB_W + SCORE_W;
  localparam int TS_W  = TB_W + TIME_W;
  localparam int CNT_W = $clog2(SCORE_W + TIME_W + 1);
  localparam logic [SCORE_W-1:0] SAT = SCORE_W'(SCORE_MAX);

  conv_state_t state, state_nxt;

  logic [CNT_W-1:0]          cnt;
  logic [SS_W-1:0]           s_scr, s_step;
  logic [TS_W-1:0]           t_scr, t_step;
  logic [SCORE_W+TIME_W-1:0] last_conv, snap;
  logic [SCORE_W-1:0]        score_sat;
  logic                      pending, trigger, s_last, t_last;

  assign score_sat = (score > SAT) ? SAT : score;
  assign trigger   = start | pending | (AUTO && ({score, timer} != last_conv));
  assign s_last    = (cnt == CNT_W'(SCORE_W - 1));
  assign t_last    = (cnt == CNT_W'(TIME_W - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  bcd_shift_step #(.DIGITS(SCORE_DIGITS), .BIN_W(SCORE_W)) u_score_step (
    .din  (s_scr),
    .dout (s_step)
  );

  bcd_shift_step #(.DIGITS(TIME_DIGITS), .BIN_W(TIME_W)) u_timer_step (
    .din  (t_scr),
    .dout (t_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = CONV_S;
      CONV_S:  if (s_last)  state_nxt = CONV_T;
      CONV_T:  if (t_last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      s_scr     <= '0;
      t_scr     <= '0;
      snap      <= '0;
      last_conv <= '0;
      pending   <= 1'b0;
      score_bcd <= '0;
      timer_bcd <= '0;
    end else begin
      // requests arriving mid-conversion collapse into one follow-up run
      if (state == IDLE) pending <= 1'b0;
      else if (start)    pending <= 1'b1;

      case (state)
        IDLE: begin
          if (trigger) begin
            s_scr <= {{SB_W{1'b0}}, score_sat};
            t_scr <= {{TB_W{1'b0}}, timer};
            snap  <= {score, timer};
            cnt   <= '0;
          end
        end
        CONV_S: begin
          s_scr <= s_step;
          cnt   <= s_last ? '0 : cnt + CNT_W'(1);
        end
        CONV_T: begin
          t_scr <= t_step;
          cnt   <= cnt + CNT_W'(1);
          if (t_last) begin
            score_bcd <= s_scr[SS_W-1 -: SB_W];
            timer_bcd <= t_step[TS_W-1 -: TB_W];
            last_conv <= snap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_converter.sv
// tb/tb_bcd_display_converter.sv - self-checking bench for bcd_display_converter (AUTO=1 and AUTO=0)
module tb_bcd_display_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] score = '0;
  logic [5:0]  timer = '0;

  logic [15:0] sb_a, sb_m;
  logic [7:0]  tb_a, tb_m;
  logic        busy_a, done_a, busy_m, done_m;

  int checks = 0;
  int passed = 0;
  int m_done_cnt = 0;
  int lat;

  always #10 clk = ~clk;

  bcd_display_converter #(.SCORE_W(14), .TIME_W(6), .SCORE_MAX(9999), .AUTO(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .score(score), .timer(timer),
    .score_bcd(sb_a), .timer_bcd(tb_a), .busy(busy_a), .done(done_a)
  );

  bcd_display_converter #(.SCORE_W(14), .TIME_W(6), .SCORE_MAX(9999), .AUTO(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start), .score(score), .timer(timer),
    .score_bcd(sb_m), .timer_bcd(tb_m), .busy(busy_m), .done(done_m)
  );

  function automatic logic [15:0] exp_score(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] exp_timer(input int t);
    return {4'(t / 10), 4'(t % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: index 0 = AUTO=1 instance, index 1 = AUTO=0 instance.
  // phase counts cycles since the trigger; outputs appear in cycle 21.
  int          m_phase [2];
  logic        m_pend  [2];
  logic [19:0] m_last  [2];
  logic [19:0] m_snap  [2];
  logic [15:0] m_sb    [2];
  logic [7:0]  m_tb    [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] <= 0;
        m_pend[i]  <= 1'b0;
        m_last[i]  <= '0;
        m_snap[i]  <= '0;
        m_sb[i]    <= '0;
        m_tb[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_phase[i] == 0) begin
          if (start || m_pend[i] || ((i == 0) && ({score, timer} != m_last[i]))) begin
            m_snap[i]  <= {score, timer};
            m_pend[i]  <= 1'b0;
            m_phase[i] <= 1;
          end
        end else begin
          if (start) m_pend[i] <= 1'b1;
          if (m_phase[i] == 20) begin
            m_sb[i]   <= exp_score(int'(m_snap[i][19:6]));
            m_tb[i]   <= exp_timer(int'(m_snap[i][5:0]));
            m_last[i] <= m_snap[i];
          end
          m_phase[i] <= (m_phase[i] == 21) ? 0 : m_phase[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_a",  32'(busy_a), 32'(m_phase[0] != 0));
      check("done_a",  32'(done_a), 32'(m_phase[0] == 21));
      check("score_a", 32'(sb_a),   32'(m_sb[0]));
      check("timer_a", 32'(tb_a),   32'(m_tb[0]));
      check("busy_m",  32'(busy_m), 32'(m_phase[1] != 0));
      check("done_m",  32'(done_m), 32'(m_phase[1] == 21));
      check("score_m", 32'(sb_m),   32'(m_sb[1]));
      check("timer_m", 32'(tb_m),   32'(m_tb[1]));
      if (done_m) m_done_cnt++;
    end
  end

  task automatic wait_done(input bit use_m, output int n);
    n = 0;
    repeat (100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if ((use_m ? done_m : done_a) === 1'b1) return;
    end
    check("done_timeout", 32'd0, 32'd1);
    n = -1;
  endtask

  task automatic wait_idle();
    repeat (200) begin
      @(negedge clk);
      if (!busy_a && !busy_m) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply(input int s, input int t);
    @(posedge clk);
    #2;
    score = 14'(s);
    timer = 6'(t);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  int          sat_in  [6] = '{9999, 10000, 12000, 16383, 0, 9998};
  logic [15:0] sat_exp [6] = '{16'h9999, 16'h9999, 16'h9999, 16'h9999, 16'h0000, 16'h9998};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    score = 14'd0;
    timer = 6'd60;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_score", 32'(sb_a), 32'h0);
    check("reset_timer", 32'(tb_a), 32'h0);
    check("reset_busy",  32'(busy_a), 32'h0);
    check("reset_done",  32'(done_a), 32'h0);

    // first cycle after release triggers on timer=60 vs reset snapshot
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_done(1'b0, lat);
    check("lat_first", 32'(lat), 32'd21);
    check("first_score", 32'(sb_a), 32'h0000);
    check("first_timer", 32'(tb_a), 32'h60);
    check("manual_idle", 32'(busy_m), 32'h0);

    wait_idle();
    apply(1234, 7);
    wait_done(1'b0, lat);
    check("lat_1234", 32'(lat), 32'd21);
    check("score_1234", 32'(sb_a), 32'h1234);
    check("timer_07", 32'(tb_a), 32'h07);
    @(negedge clk);
    check("done_one_cycle", 32'(done_a), 32'h0);

    for (int k = 0; k < 6; k++) begin
      wait_idle();
      apply(sat_in[k], 45);
      wait_done(1'b0, lat);
      check("saturation", 32'(sb_a), 32'(sat_exp[k]));
      check("timer_45", 32'(tb_a), 32'h45);
    end

    // change during CONV_S is ignored by the running conversion, then picked up
    wait_idle();
    apply(5, 7);
    repeat (5) @(posedge clk);
    #2 score = 14'd6;
    wait_done(1'b0, lat);
    check("mid_change_first", 32'(sb_a), 32'h0005);
    wait_done(1'b0, lat);
    check("mid_change_second", 32'(sb_a), 32'h0006);

    wait_idle();
    m_done_cnt = 0;
    pulse_start();
    repeat (3) @(posedge clk);
    pulse_start();
    repeat (4) @(posedge clk);
    pulse_start();
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("manual_done_count", 32'(m_done_cnt), 32'd2);
    check("manual_score", 32'(sb_m), 32'h0006);
    check("manual_timer", 32'(tb_m), 32'h07);
    check("manual_busy_end", 32'(busy_m), 32'h0);

    wait_idle();
    apply(42, 33);
    repeat (8) @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(busy_a), 32'h0);
    check("arst_done",  32'(done_a), 32'h0);
    check("arst_score", 32'(sb_a), 32'h0);
    check("arst_timer", 32'(tb_a), 32'h0);
    score = 14'd0;
    timer = 6'd0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("post_rst_busy", 32'(busy_a), 32'h0);
    check("post_rst_score", 32'(sb_a), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
